// File: rtl/fetch_prefetch_buffer_if.sv
// fetch_prefetch_buffer_if: fetch memory port between the prefetch buffer and instruction memory.
//   mem_req/mem_addr   : fetch request and 4-aligned byte address (buffer -> memory)
//   mem_ready          : memory accepts the request this cycle (memory -> buffer)
//   mem_rvalid/mem_rdata : in-order response word (memory -> buffer)
interface fetch_prefetch_buffer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ready, mem_rvalid, mem_rdata);
    modport slave (input mem_req, mem_addr, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: in-order instruction prefetch FIFO feeding a dual-issue scheduler.
//   clk, n_rst        : clock, asynchronous active-low reset
//   consume           : instructions retired from the head this cycle (3 acts as 2)
//   redirect, redirect_pc : flush and restart fetch at redirect_pc (low bits ignored)
//   mem               : fetch memory port (request/accept, in-order responses)
//   instruction0/1, pc0, valid0/1 : two oldest entries and the head PC
//   nothing_filled, count : occupancy
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [1:0]             consume,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    fetch_prefetch_buffer_if.master mem,
    output logic [31:0]            instruction0,
    output logic [31:0]            instruction1,
    output logic [31:0]            pc0,
    output logic                   valid0,
    output logic                   valid1,
    output logic                   nothing_filled,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   fifo_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d, req_n, eff;
    logic [OW-1:0] out_q, out_d, drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d, new_pc;
    logic          accept, resp, push;

    always_comb begin
        // Credit check counts in-flight words so a response always has a free slot.
        mem.mem_req  = n_rst && !redirect && (32'(count_q) + 32'(out_q) < 32'(DEPTH))
                       && (32'(out_q) < 32'(MAX_OUT));
        mem.mem_addr = fetch_pc_q;
        accept       = mem.mem_req && mem.mem_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp         = mem.mem_rvalid && out_q != '0;
        push         = resp && drop_q == '0 && !redirect;
        req_n        = consume[1] ? (AW+1)'(2) : (AW+1)'(consume[0]);
        eff          = (count_q < req_n) ? count_q : req_n;
        new_pc       = redirect_pc & ~32'd3;
        out_d        = out_q + OW'(accept) - OW'(resp);
        head_d       = redirect ? tail_q : head_q + AW'(eff);
        tail_d       = tail_q + AW'(push);
        count_d      = redirect ? '0 : count_q + (AW+1)'(push) - eff;
        fetch_pc_d   = redirect ? new_pc : fetch_pc_q + (accept ? 32'd4 : 32'd0);
        head_pc_d    = redirect ? new_pc : head_pc_q + (32'(eff) << 2);
        // Everything still in flight after a redirect belongs to the old stream.
        drop_d       = redirect ? out_d : drop_q - OW'(resp && drop_q != '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[tail_q] <= mem.mem_rdata;
    end

    assign valid0         = count_q != '0;
    assign valid1         = count_q > (AW+1)'(1);
    assign nothing_filled = count_q == '0;
    assign count          = count_q;
    assign pc0            = head_pc_q;
    assign instruction0   = valid0 ? fifo_q[head_q] : 32'd0;
    assign instruction1   = valid1 ? fifo_q[head_q + AW'(1)] : 32'd0;

    a_resp_tracked: assert property (@(posedge clk) disable iff (!n_rst) mem.mem_rvalid |-> out_q != '0);
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: randomized scoreboard bench for fetch_prefetch_buffer.
module tb_fetch_prefetch_buffer;
    localparam int          DEPTH    = 8;
    localparam int          MAX_OUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { int cnt; logic [31:0] w0, w1, pc0; } snap_t;

    logic        clk = 0;
    logic        n_rst;
    logic [1:0]  consume;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction0, instruction1, pc0;
    logic        valid0, valid1, nothing_filled;
    logic [3:0]  count;

    fetch_prefetch_buffer_if mif();

    fetch_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .n_rst(n_rst), .consume(consume), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem(mif), .instruction0(instruction0),
        .instruction1(instruction1), .pc0(pc0), .valid0(valid0), .valid1(valid1),
        .nothing_filled(nothing_filled), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, nreq = 0;
    pend_t       pend[$];
    bit          infl[$];
    logic [31:0] mbuf[$];
    snap_t       snaps[$];
    logic [31:0] fpc, hpc;

    function automatic logic [31:0] word_at(logic [31:0] a);
        return (a[5:2] == 4'd7) ? 32'd0 : a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, " mem_req"}, 32'(mif.mem_req), 0);
        chk({tag, " count"}, 32'(count), 0);
        chk({tag, " nothing_filled"}, 32'(nothing_filled), 1);
        chk({tag, " valid0"}, 32'(valid0), 0);
        chk({tag, " valid1"}, 32'(valid1), 0);
        chk({tag, " instruction0"}, instruction0, 0);
        chk({tag, " instruction1"}, instruction1, 0);
        chk({tag, " pc0"}, pc0, RESET_PC);
    endtask

    task automatic model_reset();
        pend.delete(); infl.delete(); mbuf.delete(); snaps.delete();
        fpc = RESET_PC; hpc = RESET_PC;
    endtask

    // Monitor: after each edge compare the DUT against the predicted state.
    initial forever begin
        snap_t s;
        @(posedge clk); #1;
        if (snaps.size() != 0) begin
            s = snaps.pop_front();
            chk("count", 32'(count), s.cnt);
            chk("valid0", 32'(valid0), 32'(s.cnt >= 1));
            chk("valid1", 32'(valid1), 32'(s.cnt >= 2));
            chk("nothing_filled", 32'(nothing_filled), 32'(s.cnt == 0));
            chk("instruction0", instruction0, s.w0);
            chk("instruction1", instruction1, s.w1);
            chk("pc0", pc0, s.pc0);
        end
    end

    // Driver, memory model and reference model.
    initial begin
        bit directed, exp_req, st, acc;
        int eff;
        snap_t s;
        n_rst = 0; consume = 0; redirect = 0; redirect_pc = 0;
        mif.mem_ready = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
        model_reset();
        #12;
        chk_reset_outputs("reset");
        @(negedge clk); n_rst = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            directed = cyc < 24;
            if (cyc == 24) begin
                chk("fill count", 32'(count), DEPTH);
                chk("fill requests", nreq, DEPTH);
            end
            if (cyc == 1500) begin
                #3 n_rst = 0;
                consume = 0; redirect = 0; mif.mem_ready = 0; mif.mem_rvalid = 0;
                #1 chk_reset_outputs("midreset");
                model_reset();
                @(negedge clk); n_rst = 1;
                continue;
            end
            redirect    = !directed && ($urandom % 25 == 0);
            redirect_pc = $urandom;
            consume     = directed ? 2'd0
                        : (($urandom % 4) < (((cyc / 200) % 2 != 0) ? 3 : 1)) ? 2'($urandom % 4) : 2'd0;
            mif.mem_ready = directed ? 1'b1 : ($urandom % 4 != 0);
            if (pend.size() != 0 && pend[0].due <= cyc && (directed || $urandom % 5 != 0)) begin
                mif.mem_rvalid = 1;
                mif.mem_rdata  = word_at(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mif.mem_rvalid = 0;
                mif.mem_rdata  = $urandom;
            end
            #1;
            exp_req = !redirect && (mbuf.size() + infl.size() < DEPTH) && (infl.size() < MAX_OUT);
            chk("mem_req", 32'(mif.mem_req), 32'(exp_req));
            if (mif.mem_req && exp_req) chk("mem_addr", mif.mem_addr, fpc);
            if (mif.mem_req && mif.mem_ready) begin
                pend.push_back('{mif.mem_addr, cyc + (directed ? 3 : int'($urandom_range(1, 6)))});
                nreq++;
            end
            acc = exp_req && mif.mem_ready;
            st = 1;
            if (mif.mem_rvalid && infl.size() != 0) st = infl.pop_front();
            if (redirect) begin
                foreach (infl[i]) infl[i] = 1;
                mbuf.delete();
                fpc = {redirect_pc[31:2], 2'b00};
                hpc = fpc;
            end else begin
                eff = (consume == 2'd3) ? 2 : int'(consume);
                if (eff > mbuf.size()) eff = mbuf.size();
                repeat (eff) void'(mbuf.pop_front());
                hpc = hpc + 32'(4 * eff);
                if (mif.mem_rvalid && !st) mbuf.push_back(mif.mem_rdata);
                if (acc) begin
                    infl.push_back(0);
                    fpc = fpc + 32'd4;
                end
            end
            s.cnt = mbuf.size();
            s.w0  = (mbuf.size() > 0) ? mbuf[0] : 32'd0;
            s.w1  = (mbuf.size() > 1) ? mbuf[1] : 32'd0;
            s.pc0 = hpc;
            snaps.push_back(s);
        end
        @(posedge clk); #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Parametrised in-order instruction prefetch buffer for the dual-issue front end; next generation of the fixed six-slot fetch cache.
- Issues sequential word fetches to a latency-variable memory port with a request/response handshake and holds up to DEPTH instructions in a circular FIFO.
- Presents the two oldest instructions, with PCs and valid bits, to the scheduler; the scheduler retires 0, 1 or 2 per cycle.
- Supports redirect/flush, discarding in-flight responses; emptiness comes from valid state, never from a zero instruction word.

Parameters:
DEPTH, 8, buffer entries; power of two, >= 4
MAX_OUT, 4, maximum outstanding memory requests, 1..DEPTH
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
consume  input  2  instructions retired from head this cycle (0, 1 or 2)
redirect  input  1  flush buffer and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0
mem_req  output  1  fetch request valid
mem_addr  output  32  fetch word address (byte address, 4-aligned)
mem_ready  input  1  memory accepts request when mem_req && mem_ready
mem_rvalid  input  1  response valid; responses return in request order
mem_rdata  input  32  response instruction word
instruction0  output  32  head instruction; 0 when !valid0
instruction1  output  32  head+1 instruction; 0 when !valid1
pc0  output  32  PC of instruction0
valid0  output  1  count >= 1
valid1  output  1  count >= 2
nothing_filled  output  1  count == 0
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
Reset (async, n_rst low):
- head = tail = count = outstanding = drop = 0; fetch_pc = RESET_PC; head_pc = RESET_PC.
- Outputs: mem_req 0, nothing_filled 1, valid0/valid1 0, instructions 0, pc0 = RESET_PC.
- All storage is registered; no output combinationally depends on mem_rdata.
Request issue:
- mem_req = !redirect && (count + outstanding < DEPTH) && (outstanding < MAX_OUT).
- mem_addr = fetch_pc; fetch_pc += 4 on accept, wrapping modulo 2^32.
- On accept, outstanding increments.
- mem_req stays high until accepted while its condition holds; mem_addr is stable while mem_req is high and not accepted.
Response:
- On mem_rvalid, outstanding decrements.
- If drop != 0: decrement drop and discard the word.
- Otherwise write the word at tail, advance tail modulo DEPTH, and increment count.
- Credit rule guarantees no overflow. A response while outstanding == 0 is a protocol error: ignore it and assert in simulation.
Consume:
- eff = min(consume, count). Value 3 is treated as 2.
- head += eff; head_pc += 4*eff.
- Same-cycle push and pop: count_next = count + push - eff. A write in the same cycle is not visible at the outputs until the next cycle (1-cycle response-to-output latency).
Redirect (highest priority):
- head = tail, count = 0, fetch_pc = redirect_pc, head_pc = redirect_pc.
- drop_next = outstanding_next, which includes any request accepted this cycle (none, since mem_req is 0) minus any response arriving this cycle. That response is itself discarded.
- consume is ignored that cycle.
- First new request is issued the cycle after redirect.
Reset mid-operation:
- In-flight responses after n_rst rises are not tracked. The memory side is reset together with this block.

Test Plan:
- Reset, mem_ready=1, fixed 3-cycle response latency, consume=0 -> exactly 8 requests at addresses 0x0..0x1C, then mem_req=0; count reaches 8; instruction0/1 = words at 0x0/0x4; pc0=0.
- Full buffer, consume=2 for one cycle -> count 6; pc0=0x8; mem_req reasserts the next cycle with mem_addr=0x20.
- count=1, consume=2 -> clamped to 1; nothing_filled=1, valid0=0, instruction0=0, pc0 advanced by 4.
- 3 requests outstanding, redirect with redirect_pc=0x100 -> count=0; next 3 responses discarded; first request at 0x100; first buffered word is the response to 0x100.
- Response arrives in the same cycle as consume=1 with count=1 -> count stays 1; new word becomes instruction0 the next cycle.
- n_rst pulsed low mid-stream (asynchronously, between clock edges) -> all outputs return to reset values immediately; fetch restarts at RESET_PC.
